// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and default width for the serial subtractor
package serial_sub_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit x - y - borrow_in cell
module full_subtractor (
  input  logic i_x,
  input  logic i_y,
  input  logic i_borrow_in,
  output logic o_diff,
  output logic o_borrow_out
);
  assign o_diff       = i_x ^ i_y ^ i_borrow_in;
  assign o_borrow_out = (~i_x & i_y) | (~i_x & i_borrow_in) | (i_y & i_borrow_in);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - borrow_in; optional o_ovf via SERIAL_SUBTRACTOR_OVF_EN
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_borrow_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             o_ovf,
`endif
  output logic             o_borrow_out
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_sa, r_sb, r_sd;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             w_d, w_br, w_load, w_last;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             r_am, r_bm;
`endif

  full_subtractor u_fs (
    .i_x         (r_sa[0]),
    .i_y         (r_sb[0]),
    .i_borrow_in (r_br),
    .o_diff      (w_d),
    .o_borrow_out(w_br)
  );

  // next state and status outputs; DONE accepts a new start for back-to-back operation
  always_comb begin
    w_load = i_start && (r_state == IDLE || r_state == DONE);
    w_last = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
    w_next = w_load ? RUN : w_last ? DONE : (r_state == DONE) ? IDLE : r_state;
    o_busy = r_state == RUN;
    o_done = r_state == DONE;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  // datapath; the result is published on the edge entering DONE so it is valid while o_done is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa         <= '0;
      r_sb         <= '0;
      r_sd         <= '0;
      r_br         <= 1'b0;
      r_cnt        <= '0;
      o_diff       <= '0;
      o_borrow_out <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      r_am         <= 1'b0;
      r_bm         <= 1'b0;
      o_ovf        <= 1'b0;
`endif
    end else if (w_load) begin
      r_sa  <= i_a;
      r_sb  <= i_b;
      r_br  <= i_borrow_in;
      r_cnt <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      r_am  <= i_a[WIDTH-1];
      r_bm  <= i_b[WIDTH-1];
`endif
    end else if (r_state == RUN) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_br  <= w_br;
      r_sd  <= {w_d, r_sd[WIDTH-1:1]};
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        o_diff       <= {w_d, r_sd[WIDTH-1:1]};
        o_borrow_out <= w_br;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        o_ovf        <= (r_am != r_bm) && (w_d != r_am);
`endif
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: vector table, directed handshake/reset sequences and random ops vs. arithmetic model
module tb_serial_subtractor;
  localparam int W = 8;
  logic         clk = 0, rst_n = 0, i_start = 0, i_borrow_in = 0;
  logic [W-1:0] i_a = 0, i_b = 0;
  logic         o_busy, o_done, o_borrow_out;
  logic [W-1:0] o_diff;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         o_ovf;
`endif
  int n_cmp = 0, n_err = 0;
  logic [W-1:0] last_d  = 0;
  logic         last_bo = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_borrow_in (i_borrow_in),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_diff      (o_diff),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .o_ovf       (o_ovf),
`endif
    .o_borrow_out(o_borrow_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo, ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (!o_done && c < 40) begin
      chk("busy_run", {31'd0, o_busy}, 1);
      chk("hold_diff", {24'd0, o_diff}, {24'd0, last_d});
      chk("hold_bo", {31'd0, o_borrow_out}, {31'd0, last_bo});
      @(negedge clk);
      c++;
    end
  endtask

  task automatic check_result(input string nm, input int c, input logic [W-1:0] d, input logic bo, input logic ovf);
    chk({nm, "_lat"}, c, 9);
    chk({nm, "_busy"}, {31'd0, o_busy}, 0);
    chk({nm, "_diff"}, {24'd0, o_diff}, {24'd0, d});
    chk({nm, "_bo"}, {31'd0, o_borrow_out}, {31'd0, bo});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk({nm, "_ovf"}, {31'd0, o_ovf}, {31'd0, ovf});
`endif
    last_d  = d;
    last_bo = bo;
  endtask

  task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       input logic [W-1:0] d, input logic bo, input logic ovf);
    int c;
    @(negedge clk);
    i_start = 1; i_a = a; i_b = b; i_borrow_in = bi;
    @(negedge clk);
    i_start = 0; i_a = W'($urandom); i_b = W'($urandom); i_borrow_in = 1'($urandom);
    wait_done(1, c);
    check_result(nm, c, d, bo, ovf);
  endtask

  vec_t vt[8];

  initial begin
    int c, r;
    logic [W-1:0] ra, rb, rd;
    logic rbi, rbo, rov;
    vt[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
    vt[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
    vt[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vt[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vt[5] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vt[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[7] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
    #2;
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_done", {31'd0, o_done}, 0);
    chk("rst_diff", {24'd0, o_diff}, 0);
    chk("rst_bo", {31'd0, o_borrow_out}, 0);
    @(negedge clk); rst_n = 1;
    foreach (vt[i]) do_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].bi, vt[i].d, vt[i].bo, vt[i].ovf);
    // start during RUN is ignored, then start held in DONE is accepted back-to-back
    @(negedge clk);
    i_start = 1; i_a = 8'h5A; i_b = 8'h23; i_borrow_in = 0;
    @(negedge clk); i_start = 0;
    @(negedge clk);
    @(negedge clk); i_start = 1; i_a = 8'hFF; i_b = 8'h00;
    @(negedge clk); i_start = 0;
    wait_done(4, c);
    check_result("ign", c, 8'h37, 1'b0, 1'b0);
    i_start = 1; i_a = 8'h10; i_b = 8'h20; i_borrow_in = 0;
    @(negedge clk); i_start = 0;
    chk("b2b_busy", {31'd0, o_busy}, 1);
    wait_done(1, c);
    check_result("b2b", c, 8'hF0, 1'b1, 1'b0);
    // reset mid-operation discards the result with no done pulse
    @(negedge clk);
    i_start = 1; i_a = 8'h5A; i_b = 8'h23; i_borrow_in = 0;
    @(negedge clk); i_start = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_busy", {31'd0, o_busy}, 0);
    chk("mid_done", {31'd0, o_done}, 0);
    chk("mid_diff", {24'd0, o_diff}, 0);
    chk("mid_bo", {31'd0, o_borrow_out}, 0);
    @(negedge clk); rst_n = 1;
    last_d = 0; last_bo = 0;
    for (int k = 0; k < 12; k++) begin
      chk("mid_nodone", {31'd0, o_done}, 0);
      @(negedge clk);
    end
    do_op("post_rst", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);
    // random operations against plain integer arithmetic
    for (int k = 0; k < 40; k++) begin
      ra = W'($urandom); rb = W'($urandom); rbi = 1'($urandom);
      r = int'(ra) - int'(rb) - int'(rbi);
      rd = W'(r);
      rbo = r < 0;
      rov = (ra[W-1] != rb[W-1]) && (rd[W-1] != ra[W-1]);
      do_op($sformatf("rnd%0d", k), ra, rb, rbi, rd, rbo, rov);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
